// File: rtl/game_controller.sv
// Gomoku 8x8 turn sequencer: judges each offered move, commits legal stones to
// board memory, tracks turn/move count/outcome and clears the board on (re)start.
module game_controller (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_new_game,
    input  logic       i_move_valid,
    input  logic [5:0] i_move_pos,
    output logic       o_move_ready,
    output logic       o_judge_en,
    output logic       o_judge_color,
    output logic [5:0] o_judge_pos,
    input  logic       i_judge_done,
    input  logic [1:0] i_judge_result,
    output logic       o_wr_en,
    output logic [5:0] o_wr_addr,
    output logic [1:0] o_wr_data,
    input  logic       i_wr_ack,
    output logic       o_turn,
    output logic [6:0] o_move_count,
    output logic       o_reject,
    output logic       o_game_over,
    output logic       o_winner,
    output logic       o_draw
);

    localparam logic       SIDE_RED       = 1'b0;
    localparam logic       SIDE_GREEN     = 1'b1;
    localparam logic [1:0] JUDGER_INVALID = 2'd0;
    localparam logic [1:0] JUDGER_VALID   = 2'd1;
    localparam logic [1:0] JUDGER_WIN     = 2'd2;

    localparam logic [2:0] S_CLEAR   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_JUDGE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_OVER    = 3'd5;

    logic [2:0] r_state;
    logic [5:0] r_clr_addr;
    logic [5:0] r_judge_pos;
    logic [1:0] r_result;
    logic       r_turn;
    logic [6:0] r_move_count;
    logic       r_reject;
    logic       r_game_over;
    logic       r_winner;
    logic       r_draw;

    logic       w_legal;
    logic [6:0] w_count_nxt;

    assign w_legal     = (r_result == JUDGER_VALID) || (r_result == JUDGER_WIN);
    assign w_count_nxt = r_move_count + 7'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= 6'd0;
            r_judge_pos  <= 6'd0;
            r_result     <= JUDGER_INVALID;
            r_turn       <= SIDE_RED;
            r_move_count <= 7'd0;
            r_reject     <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
            r_draw       <= 1'b0;
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    if (i_wr_ack) begin
                        r_clr_addr <= r_clr_addr + 6'd1;
                        if (r_clr_addr == 6'd63) r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (i_new_game) begin
                        r_state      <= S_CLEAR;
                        r_clr_addr   <= 6'd0;
                        r_turn       <= SIDE_RED;
                        r_move_count <= 7'd0;
                        r_game_over  <= 1'b0;
                        r_winner     <= 1'b0;
                        r_draw       <= 1'b0;
                    end else if (i_move_valid) begin
                        r_judge_pos <= i_move_pos;
                        r_state     <= S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    if (i_judge_done) begin
                        // Unknown result codes collapse to INVALID here.
                        r_result <= ((i_judge_result == JUDGER_VALID) ||
                                     (i_judge_result == JUDGER_WIN)) ?
                                    i_judge_result : JUDGER_INVALID;
                        r_state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!i_judge_done) begin
                        if (w_legal) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_reject <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_wr_ack) begin
                        r_move_count <= w_count_nxt;
                        if (r_result == JUDGER_WIN) begin
                            r_game_over <= 1'b1;
                            r_winner    <= r_turn;
                            r_state     <= S_OVER;
                        end else if (w_count_nxt == 7'd64) begin
                            r_game_over <= 1'b1;
                            r_draw      <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_turn  <= (r_turn == SIDE_RED) ? SIDE_GREEN : SIDE_RED;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_OVER: begin
                    if (i_new_game) begin
                        r_state      <= S_CLEAR;
                        r_clr_addr   <= 6'd0;
                        r_turn       <= SIDE_RED;
                        r_move_count <= 7'd0;
                        r_game_over  <= 1'b0;
                        r_winner     <= 1'b0;
                        r_draw       <= 1'b0;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Write port is shared by the clear sweep and stone commits.
    assign o_wr_en       = (r_state == S_CLEAR) || (r_state == S_WRITE);
    assign o_wr_addr     = (r_state == S_CLEAR) ? r_clr_addr : r_judge_pos;
    assign o_wr_data     = (r_state == S_CLEAR) ? 2'b00 :
                           ((r_turn == SIDE_RED) ? 2'b10 : 2'b01);
    assign o_move_ready  = (r_state == S_IDLE);
    assign o_judge_en    = (r_state == S_JUDGE);
    assign o_judge_color = r_turn;
    assign o_judge_pos   = r_judge_pos;
    assign o_turn        = r_turn;
    assign o_move_count  = r_move_count;
    assign o_reject      = r_reject;
    assign o_game_over   = r_game_over;
    assign o_winner      = r_winner;
    assign o_draw        = r_draw;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: expected board writes are queued when
// stimulus is driven and popped as the write port handshakes.
module tb_game_controller;

    localparam logic       RED   = 1'b0;
    localparam logic       GREEN = 1'b1;
    localparam logic [1:0] J_INV = 2'd0;
    localparam logic [1:0] J_VAL = 2'd1;
    localparam logic [1:0] J_WIN = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [5:0] move_pos = 6'd0;
    logic       move_ready;
    logic       judge_en;
    logic       judge_color;
    logic [5:0] judge_pos;
    logic       judge_done = 1'b0;
    logic [1:0] judge_result = 2'd0;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       wr_ack;
    logic       turn;
    logic [6:0] move_count;
    logic       reject;
    logic       game_over;
    logic       winner;
    logic       draw;

    int n_cmp = 0;
    int n_err = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [7:0] exp_q[$];

    logic       m_turn;
    logic [6:0] m_count;
    logic       m_over, m_winner, m_draw;

    game_controller dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_new_game(new_game),
        .i_move_valid(move_valid), .i_move_pos(move_pos), .o_move_ready(move_ready),
        .o_judge_en(judge_en), .o_judge_color(judge_color), .o_judge_pos(judge_pos),
        .i_judge_done(judge_done), .i_judge_result(judge_result),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_ack(wr_ack),
        .o_turn(turn), .o_move_count(move_count), .o_reject(reject),
        .o_game_over(game_over), .o_winner(winner), .o_draw(draw)
    );

    always #5 clk = ~clk;

    // Board memory model: acks after ack_delay cycles of wr_en.
    assign wr_ack = wr_en && (wait_cnt >= ack_delay);
    always @(posedge clk) begin
        if (!wr_en || wr_ack) wait_cnt <= 0;
        else                  wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n && wr_en && wr_ack) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: unexpected addr=%0d data=%b", wr_addr, wr_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%b want addr=%0d data=%b",
                             wr_addr, wr_data, e[7:2], e[1:0]);
                end
            end
        end
    end

    task automatic push_clear();
        for (int i = 0; i < 64; i++) exp_q.push_back({i[5:0], 2'b00});
        m_turn = RED; m_count = 7'd0; m_over = 1'b0; m_winner = 1'b0; m_draw = 1'b0;
    endtask

    task automatic check_status(input string tag);
        n_cmp++;
        if (turn !== m_turn || move_count !== m_count || game_over !== m_over ||
            draw !== m_draw || (m_over && !m_draw && winner !== m_winner)) begin
            n_err++;
            $display("FAIL %s: got turn=%b cnt=%0d over=%b win=%b draw=%b want %b %0d %b %b %b",
                     tag, turn, move_count, game_over, winner, draw,
                     m_turn, m_count, m_over, m_winner, m_draw);
        end
    endtask

    // Count cycles from a clear start until move_ready; expect 64.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (!move_ready && n < 300) begin n++; @(negedge clk); end
        n_cmp++;
        if (n !== 64) begin
            n_err++;
            $display("FAIL %s_clear_cycles: got %0d want 64", tag, n);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL %s_clear_writes: %0d writes missing", tag, exp_q.size());
        end
        check_status({tag, "_status"});
    endtask

    task automatic do_move(input logic [5:0] pos, input logic [1:0] res,
                           input int hold, input bit ng_poke);
        int n;
        logic legal;
        logic [5:0] ha;
        logic [1:0] hd;
        legal = (res == J_VAL) || (res == J_WIN);
        n = 0;
        while (!move_ready && n < 200) begin @(negedge clk); n++; end
        n_cmp++;
        if (!move_ready) begin
            n_err++;
            $display("FAIL move_ready_timeout: got 0 want 1");
            return;
        end
        move_valid = 1'b1;
        move_pos   = pos;
        if (legal) exp_q.push_back({pos, (m_turn == RED) ? 2'b10 : 2'b01});
        @(negedge clk);
        move_valid = 1'b0;
        move_pos   = ~pos;
        n_cmp++;
        if (judge_en !== 1'b1 || judge_color !== m_turn || judge_pos !== pos) begin
            n_err++;
            $display("FAIL judge_req: got en=%b col=%b pos=%0d want 1 %b %0d",
                     judge_en, judge_color, judge_pos, m_turn, pos);
        end
        if (ng_poke) new_game = 1'b1;
        judge_done   = 1'b1;
        judge_result = res;
        @(negedge clk);
        new_game = 1'b0;
        n_cmp++;
        if (judge_en !== 1'b0 || move_ready !== 1'b0) begin
            n_err++;
            $display("FAIL judge_drop: got en=%b ready=%b want 0 0", judge_en, move_ready);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (judge_en !== 1'b0 || wr_en !== 1'b0 || reject !== 1'b0) begin
                n_err++;
                $display("FAIL release_hold: got en=%b wr=%b rej=%b want 0 0 0",
                         judge_en, wr_en, reject);
            end
        end
        judge_done   = 1'b0;
        judge_result = J_INV;
        @(negedge clk);
        if (!legal) begin
            n_cmp++;
            if (reject !== 1'b1 || move_ready !== 1'b1 || wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL reject_pulse: got rej=%b ready=%b wr=%b want 1 1 0",
                         reject, move_ready, wr_en);
            end
            @(negedge clk);
            n_cmp++;
            if (reject !== 1'b0) begin
                n_err++;
                $display("FAIL reject_width: got %b want 0", reject);
            end
        end else begin
            n_cmp++;
            if (wr_en !== 1'b1 || reject !== 1'b0) begin
                n_err++;
                $display("FAIL write_start: got wr=%b rej=%b want 1 0", wr_en, reject);
            end
            ha = wr_addr;
            hd = wr_data;
            n = 0;
            while (!wr_ack && n < 50) begin
                @(negedge clk);
                n++;
                n_cmp++;
                if (wr_en !== 1'b1 || wr_addr !== ha || wr_data !== hd) begin
                    n_err++;
                    $display("FAIL write_hold: got %b %0d %b want 1 %0d %b",
                             wr_en, wr_addr, wr_data, ha, hd);
                end
            end
            n_cmp++;
            if (!wr_ack) begin
                n_err++;
                $display("FAIL write_ack_timeout: got 0 want 1");
            end
            @(negedge clk);
            n_cmp++;
            if (wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL write_drop: got %b want 0", wr_en);
            end
            m_count = m_count + 7'd1;
            if (res == J_WIN) begin
                m_over = 1'b1; m_winner = m_turn;
            end else if (m_count == 7'd64) begin
                m_over = 1'b1; m_draw = 1'b1;
            end else begin
                m_turn = ~m_turn;
            end
        end
        check_status("after_move");
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 2'b00 || judge_en !== 1'b0 ||
            move_ready !== 1'b0 || reject !== 1'b0 || turn !== RED || move_count !== 7'd0 ||
            game_over !== 1'b0 || draw !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: wr=%b a=%0d d=%b jen=%b rdy=%b rej=%b t=%b c=%0d o=%b dr=%b",
                     wr_en, wr_addr, wr_data, judge_en, move_ready, reject, turn,
                     move_count, game_over, draw);
        end
        push_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wait_clear("reset");
    endtask

    task automatic test_valid_move();
        do_move(6'o33, J_VAL, 0, 1'b0);
    endtask

    task automatic test_invalid();
        do_move(6'd5, J_INV, 0, 1'b1);
        do_move(6'd6, 2'd3, 1, 1'b0);
    endtask

    task automatic test_stall();
        ack_delay = 5;
        do_move(6'd10, J_VAL, 3, 1'b0);
        ack_delay = 0;
    endtask

    task automatic test_win();
        do_move(6'd11, J_VAL, 0, 1'b0);
        do_move(6'd12, J_WIN, 0, 1'b0);
        move_valid = 1'b1;
        move_pos   = 6'd20;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (move_ready !== 1'b0 || judge_en !== 1'b0 || wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL over_ignore: got rdy=%b jen=%b wr=%b want 0 0 0",
                         move_ready, judge_en, wr_en);
            end
        end
        move_valid = 1'b0;
        check_status("over_hold");
        push_clear();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_clear("newgame");
    endtask

    task automatic test_draw();
        for (int i = 0; i < 64; i++) do_move(i[5:0], J_VAL, 0, 1'b0);
        n_cmp++;
        if (move_ready !== 1'b0) begin
            n_err++;
            $display("FAIL draw_ready: got %b want 0", move_ready);
        end
    endtask

    initial begin
        m_turn = RED; m_count = 7'd0; m_over = 1'b0; m_winner = 1'b0; m_draw = 1'b0;
        test_reset();
        test_valid_move();
        test_invalid();
        test_stall();
        test_win();
        test_draw();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL final_queue: %0d writes missing", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
